// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-lane extraction and writeback source select.
// Timing contract: no handshake. Every rising clk edge loads either a bubble
// (flush), the held contents (stall) or the mem_* inputs. The wb_* outputs are
// decoded only from the registered entry, one cycle after capture.
module mem_wb_stage #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_wesel,
  input  logic [1:0]  mem_wbsel,
  input  logic [2:0]  mem_ldtype,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_dmem_rdata,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_aux,
  output logic        wb_regwrite,
  output logic [4:0]  wb_wesel,
  output logic [31:0] wb_gpr_input,
  output logic        wb_misalign
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic        regwrite_q, regwrite_d;
  logic [4:0]  wesel_q, wesel_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] aux_q, aux_d;

  // Next-entry select: flush beats stall, stall beats capture.
  always_comb begin
    regwrite_d   = regwrite_q;
    wesel_d      = wesel_q;
    wbsel_d      = wbsel_q;
    ldtype_d     = ldtype_q;
    alu_result_d = alu_result_q;
    dmem_rdata_d = dmem_rdata_q;
    pc4_d        = pc4_q;
    aux_d        = aux_q;
    if (flush) begin
      regwrite_d   = 1'b0;
      wesel_d      = 5'd0;
      wbsel_d      = WB_ALU;
      ldtype_d     = 3'd0;
      alu_result_d = 32'd0;
      dmem_rdata_d = 32'd0;
      pc4_d        = 32'd0;
      aux_d        = 32'd0;
    end else if (!stall) begin
      regwrite_d   = mem_regwrite;
      wesel_d      = mem_wesel;
      wbsel_d      = mem_wbsel;
      ldtype_d     = mem_ldtype;
      alu_result_d = mem_alu_result;
      dmem_rdata_d = mem_dmem_rdata;
      pc4_d        = mem_pc4;
      aux_d        = mem_aux;
    end
  end

  // Stage registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      wesel_q      <= 5'd0;
      wbsel_q      <= WB_ALU;
      ldtype_q     <= 3'd0;
      alu_result_q <= 32'd0;
      dmem_rdata_q <= 32'd0;
      pc4_q        <= 32'd0;
      aux_q        <= 32'd0;
    end else begin
      regwrite_q   <= regwrite_d;
      wesel_q      <= wesel_d;
      wbsel_q      <= wbsel_d;
      ldtype_q     <= ldtype_d;
      alu_result_q <= alu_result_d;
      dmem_rdata_q <= dmem_rdata_d;
      pc4_q        <= pc4_d;
      aux_q        <= aux_d;
    end
  end

  logic [1:0]  addr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic        misalign;

  assign addr = alu_result_q[1:0];

  // Lane pick: little-endian byte k sits at bits 8k+7:8k; big-endian mirrors it,
  // so byte 0 / halfword 0 are the most significant lanes.
  always_comb begin
    if (BIG_ENDIAN) begin
      byte_v = dmem_rdata_q[{~addr, 3'b000} +: 8];
      half_v = addr[1] ? dmem_rdata_q[15:0] : dmem_rdata_q[31:16];
    end else begin
      byte_v = dmem_rdata_q[{addr, 3'b000} +: 8];
      half_v = addr[1] ? dmem_rdata_q[31:16] : dmem_rdata_q[15:0];
    end
  end

  // Sign/zero extension by load type; undefined encodings behave as lw.
  always_comb begin
    case (ldtype_q)
      LD_LH:   load_v = {{16{half_v[15]}}, half_v};
      LD_LHU:  load_v = {16'd0, half_v};
      LD_LB:   load_v = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  load_v = {24'd0, byte_v};
      default: load_v = dmem_rdata_q;
    endcase
  end

  // Misalignment only matters for entries that actually write back load data.
  always_comb begin
    misalign = 1'b0;
    if (wbsel_q == WB_LOAD) begin
      case (ldtype_q)
        LD_LB, LD_LBU: misalign = 1'b0;
        LD_LH, LD_LHU: misalign = addr[0];
        default:       misalign = (addr != 2'b00);
      endcase
    end
  end

  // Writeback value select.
  always_comb begin
    case (wbsel_q)
      WB_ALU:  wb_gpr_input = alu_result_q;
      WB_LOAD: wb_gpr_input = load_v;
      WB_PC4:  wb_gpr_input = pc4_q;
      default: wb_gpr_input = aux_q;
    endcase
  end

  // GPR 0 is never written, and a misaligned load is suppressed.
  assign wb_regwrite = regwrite_q && (wesel_q != 5'd0) && !misalign;
  assign wb_wesel    = wesel_q;
  assign wb_misalign = misalign;

endmodule
